// File: rtl/rv32i_io_bus.sv
// rv32i_io_bus: data-side decoder between the RV32I core and data RAM.
// It maps a word-only I/O region at IO_BASE[31:12] holding GPIO out, debounced buttons,
// and an optional 64-bit timer with compare interrupt.
// Optional feature macro: RV32I_IO_TIMER_EN (timer, snapshot, compare, STATUS).
module rv32i_io_bus #(
    parameter int unsigned LED_WIDTH       = 4,
    parameter int unsigned BTN_WIDTH       = 2,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] IO_BASE         = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 data_mem_write,
    input  logic                 data_mem_read,
    input  logic [31:0]          data_mem_addr,
    input  logic [1:0]           store_type,
    input  logic [2:0]           load_type,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ram_write,
    output logic                 ram_read,
    output logic [31:0]          ram_addr,
    output logic [1:0]           ram_store_type,
    output logic [2:0]           ram_load_type,
    output logic [31:0]          ram_write_data,
    input  logic [31:0]          ram_read_data,
    input  logic [BTN_WIDTH-1:0] btn,
    output logic [LED_WIDTH-1:0] led,
    output logic                 timer_irq
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned CNT_W = 16;

    localparam logic [IDX_W-1:0] IDX_GPIO_OUT  = 6'h00;
    localparam logic [IDX_W-1:0] IDX_GPIO_IN   = 6'h01;
    localparam logic [IDX_W-1:0] IDX_TIMER_LO  = 6'h02;
    localparam logic [IDX_W-1:0] IDX_TIMER_HI  = 6'h03;
    localparam logic [IDX_W-1:0] IDX_TIMER_CMP = 6'h04;
    localparam logic [IDX_W-1:0] IDX_STATUS    = 6'h05;

    logic             io_sel;
    logic             io_wr;
    logic [IDX_W-1:0] reg_idx;
    logic [31:0]      io_rdata;
    logic [31:0]      timer_rdata;

    logic [LED_WIDTH-1:0] gpio_q;

    logic [BTN_WIDTH-1:0] sync1_q;
    logic [BTN_WIDTH-1:0] sync_q;
    logic [BTN_WIDTH-1:0] cand_q;
    logic [BTN_WIDTH-1:0] stable_q;
    logic [CNT_W-1:0]     cnt_q;

    // Address bits that the word-only, 64-word register file never looks at
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_mem_addr[11:8], data_mem_addr[1:0]};

    // Region decode and RAM pass-through
    assign io_sel  = (data_mem_addr[31:12] == IO_BASE[31:12]);
    assign io_wr   = data_mem_write & io_sel;
    assign reg_idx = data_mem_addr[7:2];

    assign ram_write      = data_mem_write & ~io_sel;
    assign ram_read       = data_mem_read & ~io_sel;
    assign ram_addr       = data_mem_addr;
    assign ram_store_type = store_type;
    assign ram_load_type  = load_type;
    assign ram_write_data = write_data;

    assign led = gpio_q;

    // GPIO output register; stores always write the full word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_q <= '0;
        end else if (io_wr && (reg_idx == IDX_GPIO_OUT)) begin
            gpio_q <= write_data[LED_WIDTH-1:0];
        end
    end

    // Button synchronizer and shared-counter debouncer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn;
            sync_q  <= sync1_q;
            if (sync_q != cand_q) begin
                cand_q <= sync_q;
                cnt_q  <= '0;
            end else if (cnt_q == (DEBOUNCE_CYCLES - 16'd1)) begin
                stable_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

`ifdef RV32I_IO_TIMER_EN
    logic [63:0] timer_q;
    logic [31:0] hi_snap_q;
    logic [31:0] cmp_q;
    logic        match_q;
    logic        cmp_en_q;
    logic        rd_lo;
    logic        wr_cmp;
    logic        wr_status;
    logic        match_hit;

    assign rd_lo     = data_mem_read & io_sel & (reg_idx == IDX_TIMER_LO);
    assign wr_cmp    = io_wr & (reg_idx == IDX_TIMER_CMP);
    assign wr_status = io_wr & (reg_idx == IDX_STATUS);
    assign match_hit = (timer_q[31:0] == cmp_q);
    assign timer_irq = match_q & cmp_en_q;

    // Free-running timer, high-word snapshot, compare and sticky match (set beats W1C)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            hi_snap_q <= '0;
            cmp_q     <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            cmp_en_q  <= 1'b0;
        end else begin
            timer_q <= timer_q + 64'd1;
            if (rd_lo) begin
                hi_snap_q <= timer_q[63:32];
            end
            if (wr_cmp) begin
                cmp_q <= write_data;
            end
            if (wr_status) begin
                cmp_en_q <= write_data[1];
            end
            match_q <= match_hit | (match_q & ~(wr_status & write_data[0]));
        end
    end

    // Timer-side read mux; non-timer offsets contribute zero
    always_comb begin
        timer_rdata = '0;
        case (reg_idx)
            IDX_TIMER_LO:  timer_rdata = timer_q[31:0];
            IDX_TIMER_HI:  timer_rdata = hi_snap_q;
            IDX_TIMER_CMP: timer_rdata = cmp_q;
            IDX_STATUS:    timer_rdata = {30'd0, cmp_en_q, match_q};
            default:       timer_rdata = '0;
        endcase
    end
`else
    assign timer_rdata = '0;
    assign timer_irq   = 1'b0;
`endif

    // I/O register read mux, merged with the timer contribution
    always_comb begin
        io_rdata = timer_rdata;
        case (reg_idx)
            IDX_GPIO_OUT: io_rdata = 32'(gpio_q);
            IDX_GPIO_IN:  io_rdata = 32'(stable_q);
            default:      io_rdata = timer_rdata;
        endcase
    end

    assign read_data = io_sel ? io_rdata : ram_read_data;

endmodule

// File: doc/rv32i_io_bus.md
# rv32i_io_bus

Data-side address decoder and memory-mapped peripheral block between `RV32I_Core` and `Data_Memory`. It replaces the fixed "LED = PC bits" arrangement with a software-visible I/O region. The I/O region holds:
- a parametrised GPIO output register driving the LEDs,
- a debounced button input port,
- a 64-bit cycle timer with a compare interrupt.

Accesses outside the I/O region pass through to data RAM unchanged.

## Interface
Parameters:
- `LED_WIDTH`, 4: width of the GPIO output register and `led` port (1–32).
- `BTN_WIDTH`, 2: number of button inputs (1–32).
- `DEBOUNCE_CYCLES`, 16'd50000: number of cycles an input change must be stable before it is accepted (≥2).
- `IO_BASE`, 32'h0000_1000: base of the I/O region; only bits [31:12] are compared.

Ports:
- `clk`  in  1: single clock. All registers update on the rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `data_mem_write`, `data_mem_read`  in  1: core store/load strobes.
- `data_mem_addr`  in  32: core byte address.
- `store_type`  in  2: 00=byte, 01=half, 10=word.
- `load_type`  in  3: funct3 encoding (LB/LH/LW/LBU/LHU).
- `write_data`  in  32: core store data.
- `read_data`  out  32: load data returned to the core.
- `ram_write`, `ram_read`  out  1: strobes to `Data_Memory`.
- `ram_addr`  out  32, `ram_store_type`  out  2, `ram_load_type`  out  3, `ram_write_data`  out  32: pass-through signals to RAM.
- `ram_read_data`  in  32: RAM load data.
- `btn`  in  BTN_WIDTH: raw asynchronous buttons.
- `led`  out  LED_WIDTH: registered GPIO output.
- `timer_irq`  out  1: level interrupt = match flag AND compare-enable.

## Operation
- Decode: `io_sel = (data_mem_addr[31:12] == IO_BASE[31:12])`.
  - `ram_write = data_mem_write & ~io_sel`; `ram_read = data_mem_read & ~io_sel`.
  - Address, type and data signals pass straight through to RAM.
- `read_data` is combinational: the I/O register mux when `io_sel`, otherwise `ram_read_data`.
- The I/O region is word-only.
  - Stores write the full `write_data` regardless of `store_type`.
  - Loads return the full 32-bit word regardless of `load_type`.
  - `data_mem_addr[1:0]` is ignored.
- Register map, by offset `data_mem_addr[7:2]`:
  - 0x00 GPIO_OUT (RW): `[LED_WIDTH-1:0]`. Other bits read 0.
  - 0x04 GPIO_IN (RO): debounced `btn`, zero-extended.
  - 0x08 TIMER_LO (RO): `timer[31:0]`. A load of this register latches `timer[63:32]` into `hi_snap` on the same edge.
  - 0x0C TIMER_HI (RO): `hi_snap`.
  - 0x10 TIMER_CMP (RW): 32-bit compare value.
  - 0x14 STATUS:
    - bit0 `match`: sticky; write 1 to clear.
    - bit1 `cmp_en`: RW.
  - Other offsets read 0; writes to them are ignored.
- Timer: a 64-bit counter that increments by 1 every cycle and wraps from all-ones to 0.
- Match: when `timer[31:0] == TIMER_CMP`, `match` sets on the next edge.
  - If a set and a W1C write to `match` occur in the same cycle, the set wins.
- Debouncer, shared counter:
  - `btn` passes through a 2-flop synchronizer to give `sync`.
  - If `sync != cand`: `cand <= sync` and `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= cand`. `cnt` holds at that value.
  - Else: `cnt <= cnt+1`.

## Timing
- Reset values:
  - `led` = 0, `timer` = 0, `hi_snap` = 0.
  - TIMER_CMP = 32'hFFFF_FFFF, `match` = 0, `cmp_en` = 0, `timer_irq` = 0.
  - Synchronizer flops, `cand`, `stable` = 0; `cnt` = 0.
- Reset is asynchronous. Asserting it mid-count or mid-debounce clears all state immediately.
- Store latency: register values, including `led`, update on the edge that ends the store cycle.
- Load latency: 0 cycles. `read_data` is valid in the same cycle as `data_mem_read`.
- A timer read returns the count before that edge's increment.
- `btn` to GPIO_IN latency: 2 synchronizer cycles + 1 compare cycle + `DEBOUNCE_CYCLES` stable cycles.
  - Any glitch restarts the count.
- `timer_irq` goes high 1 cycle after the compare equality is seen, if `cmp_en` is set.
  - It stays high until `match` is cleared or `cmp_en` is cleared.

## Configuration
- `RV32I_IO_TIMER_EN`:
  - Defined: timer, `hi_snap`, compare and STATUS logic are present, as described above.
  - Undefined: offsets 0x08–0x14 read 0 and ignore writes; `timer_irq` is tied 0; no timer flops are synthesised. GPIO and debounce behaviour is unchanged.

## Test plan
- GPIO path: reset, then SW 0x0000_000A to 0x1000. Require `led` = 4'hA on the next edge, `ram_write` = 0, and a load of 0x1000 returns 0x0000_000A.
- RAM pass-through: SW 0xDEADBEEF to 0x0040, then LW 0x0040. Require `ram_write`/`ram_read` asserted, `read_data` = 0xDEADBEEF, and `led` unchanged.
- Debounce (`DEBOUNCE_CYCLES`=4): `btn`=2'b01 with a 2-cycle glitch, then held. Require GPIO_IN = 0 during the glitch and GPIO_IN = 1 exactly 7 cycles after the stable edge.
- Timer snapshot: run 2^32+5 cycles (force the counter), LW 0x1008 then LW 0x100C. Require LO = the count at the load and HI = 1, even though `timer` continues counting.
- Compare/IRQ: CMP = 20, STATUS = 0x2. Require `timer_irq` to rise at cycle 21.
  - Then SW 0x3 to STATUS coinciding with a new match. Require `match` to remain 1.
- Reset mid-operation: assert `reset_n` = 0 mid-debounce with `led`=0xF. Require all outputs = reset values asynchronously, before the next edge.
